// File: rtl/cv_pad_ctrl_if.sv
// cv_pad_ctrl_if: controller-port bundle between hps_io and console pins
// master drives pad inputs, slave (the engine) drives the pin outputs
interface cv_pad_ctrl_if #(
  parameter int NUM_PADS = 2
);
  logic [32*NUM_PADS-1:0] joy_i;
  logic [1:0]             map_rot_i;
  logic [2*NUM_PADS-1:0]  af_en_i;
  logic [NUM_PADS-1:0]    sel_key_n_i;
  logic [NUM_PADS-1:0]    sel_joy_n_i;
  logic [8*NUM_PADS-1:0]  spin_delta_i;
  logic [NUM_PADS-1:0]    spin_stb_i;
  logic [4*NUM_PADS-1:0]  ctrl_dir_o;
  logic [NUM_PADS-1:0]    ctrl_p6_o;
  logic [NUM_PADS-1:0]    quad_a_o;
  logic [NUM_PADS-1:0]    quad_b_o;

  modport master (
    output joy_i, map_rot_i, af_en_i,
    output sel_key_n_i, sel_joy_n_i,
    output spin_delta_i, spin_stb_i,
    input  ctrl_dir_o, ctrl_p6_o,
    input  quad_a_o, quad_b_o
  );

  modport slave (
    input  joy_i, map_rot_i, af_en_i,
    input  sel_key_n_i, sel_joy_n_i,
    input  spin_delta_i, spin_stb_i,
    output ctrl_dir_o, ctrl_p6_o,
    output quad_a_o, quad_b_o
  );
endinterface

// File: rtl/cv_pad_ctrl.sv
// cv_pad_ctrl: ColecoVision controller-port engine
// player rotation, per-button autofire, roller quadrature
module cv_pad_ctrl #(
  parameter int NUM_PADS = 2,
  parameter int AF_HALF  = 178977,
  parameter int SPIN_DIV = 2684
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ce_10m7,
  cv_pad_ctrl_if.slave  bus
);
  localparam int AW = $clog2(AF_HALF + 1);
  localparam int SW = $clog2(SPIN_DIV + 1);

  logic [20*NUM_PADS-1:0] joy_q;
  logic [NUM_PADS-1:0]    selk_q, selj_q;
  logic [2*NUM_PADS-1:0]  af_en_q;
  logic [AW-1:0]          af_cnt_q, af_cnt_d;
  logic                   af_ph_q, af_ph_d;
  logic [SW-1:0]          sp_cnt_q, sp_cnt_d;
  logic                   step;
  logic [4*NUM_PADS-1:0]  dir_q, dir_d;
  logic [NUM_PADS-1:0]    p6_q, p6_d;
  logic signed [9:0]      acc_q [NUM_PADS];
  logic signed [9:0]      acc_d [NUM_PADS];
  logic [1:0]             qd_q [NUM_PADS];
  logic [1:0]             qd_d [NUM_PADS];
  logic [NUM_PADS-1:0]    qa, qb;

  // keypad lines, first pressed key in scan order wins
  function automatic logic [3:0] key_code(
    input logic [19:0] w
  );
    logic [3:0] c;
    c = 4'b1111;
    priority case (1'b1)
      w[8]:    c = 4'b0011;
      w[9]:    c = 4'b1110;
      w[10]:   c = 4'b1101;
      w[11]:   c = 4'b0110;
      w[12]:   c = 4'b0001;
      w[13]:   c = 4'b1001;
      w[14]:   c = 4'b0111;
      w[15]:   c = 4'b1100;
      w[16]:   c = 4'b1000;
      w[17]:   c = 4'b1011;
      w[6]:    c = 4'b1010;
      w[7]:    c = 4'b0101;
      w[18]:   c = 4'b0100;
      w[19]:   c = 4'b0010;
      default: c = 4'b1111;
    endcase
    return c;
  endfunction

  // shared autofire and roller-step timebases
  always_comb begin
    af_cnt_d = af_cnt_q;
    af_ph_d  = af_ph_q;
    sp_cnt_d = sp_cnt_q;
    step     = 1'b0;
    if (ce_10m7) begin
      if (af_cnt_q == AW'(AF_HALF - 1)) begin
        af_cnt_d = '0;
        af_ph_d  = ~af_ph_q;
      end else begin
        af_cnt_d = af_cnt_q + AW'(1);
      end
      if (sp_cnt_q == SW'(SPIN_DIV - 1)) begin
        sp_cnt_d = '0;
        step     = 1'b1;
      end else begin
        sp_cnt_d = sp_cnt_q + SW'(1);
      end
    end
  end

  // pin levels from the registered input stage
  always_comb begin
    int         pl;
    logic [19:0] w;
    logic       f1, f2, p;
    logic [3:0] d;
    pl    = 0;
    w     = '0;
    f1    = 1'b0;
    f2    = 1'b0;
    p     = 1'b1;
    d     = 4'b1111;
    dir_d = '1;
    p6_d  = '1;
    for (int k = 0; k < NUM_PADS; k++) begin
      pl = (k + int'(bus.map_rot_i)) % NUM_PADS;
      w  = joy_q[20*pl +: 20];
      f1 = w[4] & (af_en_q[2*k] ? af_ph_q : 1'b1);
      f2 = w[5] & (af_en_q[2*k+1] ? af_ph_q : 1'b1);
      d  = 4'b1111;
      p  = 1'b1;
      if (!selk_q[k]) begin
        d = d & key_code(w);
        p = p & ~f2;
      end
      if (!selj_q[k]) begin
        d = d & ~{w[3], w[2], w[1], w[0]};
        p = p & ~f1;
      end
      dir_d[4*k +: 4] = d;
      p6_d[k]         = p;
    end
  end

  // roller accumulator drain and quadrature stepping
  always_comb begin
    logic signed [11:0] sum;
    sum = '0;
    for (int k = 0; k < NUM_PADS; k++) begin
      qd_d[k] = qd_q[k];
      sum = {{2{acc_q[k][9]}}, acc_q[k]};
      if (bus.spin_stb_i[k]) begin
        sum = sum + {{4{bus.spin_delta_i[8*k+7]}},
                     bus.spin_delta_i[8*k +: 8]};
      end
      if (step && acc_q[k] != 10'sd0) begin
        if (!acc_q[k][9]) begin
          sum     = sum - 12'sd1;
          qd_d[k] = {~qd_q[k][0], qd_q[k][1]};
        end else begin
          sum     = sum + 12'sd1;
          qd_d[k] = {qd_q[k][0], ~qd_q[k][1]};
        end
      end
      if (sum > 12'sd511) begin
        acc_d[k] = 10'sd511;
      end else if (sum < -12'sd511) begin
        acc_d[k] = -10'sd511;
      end else begin
        acc_d[k] = sum[9:0];
      end
    end
  end

  // state registers with synchronous reset
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      joy_q    <= '0;
      selk_q   <= '1;
      selj_q   <= '1;
      af_en_q  <= '0;
      af_cnt_q <= '0;
      af_ph_q  <= 1'b1;
      sp_cnt_q <= '0;
      dir_q    <= '1;
      p6_q     <= '1;
      for (int k = 0; k < NUM_PADS; k++) begin
        acc_q[k] <= '0;
        qd_q[k]  <= 2'b00;
      end
    end else begin
      for (int k = 0; k < NUM_PADS; k++) begin
        joy_q[20*k +: 20] <= bus.joy_i[32*k +: 20];
        acc_q[k] <= acc_d[k];
        qd_q[k]  <= qd_d[k];
      end
      selk_q   <= bus.sel_key_n_i;
      selj_q   <= bus.sel_joy_n_i;
      af_en_q  <= bus.af_en_i;
      af_cnt_q <= af_cnt_d;
      af_ph_q  <= af_ph_d;
      sp_cnt_q <= sp_cnt_d;
      dir_q    <= dir_d;
      p6_q     <= p6_d;
    end
  end

  // split quadrature state into the two phase pins
  always_comb begin
    qa = '0;
    qb = '0;
    for (int k = 0; k < NUM_PADS; k++) begin
      qa[k] = qd_q[k][1];
      qb[k] = qd_q[k][0];
    end
  end

  assign bus.ctrl_dir_o = dir_q;
  assign bus.ctrl_p6_o  = p6_q;
  assign bus.quad_a_o   = qa;
  assign bus.quad_b_o   = qb;
endmodule

// File: tb/tb_cv_pad_ctrl.sv
// tb_cv_pad_ctrl: directed and random stimulus against
// a cycle-level behavioural model of the pad engine
module tb_cv_pad_ctrl;
  localparam int NP  = 2;
  localparam int AFH = 4;
  localparam int SPD = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b1;

  cv_pad_ctrl_if #(.NUM_PADS(NP)) bus();

  cv_pad_ctrl #(
    .NUM_PADS(NP),
    .AF_HALF(AFH),
    .SPIN_DIV(SPD)
  ) dut (
    .clk_sys(clk),
    .reset(rst),
    .ce_10m7(ce),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0]   rj [NP];
  logic [NP-1:0] rsk, rsj;
  logic [2*NP-1:0] raf;
  logic [3:0]    edir [NP];
  logic          ep6 [NP];
  int            af_ticks, sp_ticks;
  int            acc [NP];
  int            qpos [NP];

  int kbit [14] = '{8, 9, 10, 11, 12, 13, 14, 15, 16, 17,
                    6, 7, 18, 19};
  logic [3:0] kcode [14] = '{4'b0011, 4'b1110, 4'b1101,
    4'b0110, 4'b0001, 4'b1001, 4'b0111, 4'b1100, 4'b1000,
    4'b1011, 4'b1010, 4'b0101, 4'b0100, 4'b0010};

  function automatic logic [3:0] keyc(logic [31:0] w);
    for (int i = 0; i < 14; i++)
      if (w[kbit[i]]) return kcode[i];
    return 4'b1111;
  endfunction

  function automatic logic [1:0] qab(int p);
    case (((p % 4) + 4) % 4)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  task automatic chk(string nm, int got, int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d (%b) want=%0d (%b)",
               nm, got, got[7:0], want, want[7:0]);
    end
  endtask

  task automatic model_edge();
    logic       ph, f1, f2, step;
    logic [31:0] w;
    int         pl, s, n;
    if (rst) begin
      for (int k = 0; k < NP; k++) begin
        rj[k] = '0; edir[k] = 4'hF; ep6[k] = 1'b1;
        acc[k] = 0; qpos[k] = 0;
      end
      rsk = '1; rsj = '1; raf = '0;
      af_ticks = 0; sp_ticks = 0;
    end else begin
      ph = ((af_ticks / AFH) % 2) == 0;
      for (int k = 0; k < NP; k++) begin
        pl = (k + int'(bus.map_rot_i)) % NP;
        w  = rj[pl];
        f1 = w[4] && (raf[2*k] ? ph : 1'b1);
        f2 = w[5] && (raf[2*k+1] ? ph : 1'b1);
        edir[k] = 4'hF;
        ep6[k]  = 1'b1;
        if (!rsk[k]) begin
          edir[k] = edir[k] & keyc(w);
          if (f2) ep6[k] = 1'b0;
        end
        if (!rsj[k]) begin
          if (w[3]) edir[k][3] = 1'b0;
          if (w[2]) edir[k][2] = 1'b0;
          if (w[1]) edir[k][1] = 1'b0;
          if (w[0]) edir[k][0] = 1'b0;
          if (f1) ep6[k] = 1'b0;
        end
      end
      for (int k = 0; k < NP; k++) rj[k] = bus.joy_i[32*k +: 32];
      rsk = bus.sel_key_n_i;
      rsj = bus.sel_joy_n_i;
      raf = bus.af_en_i;
      step = 1'b0;
      if (ce) begin
        step = ((sp_ticks + 1) % SPD) == 0;
        sp_ticks++;
        af_ticks++;
      end
      for (int k = 0; k < NP; k++) begin
        s = (acc[k] > 0) ? 1 : (acc[k] < 0) ? -1 : 0;
        n = acc[k];
        if (bus.spin_stb_i[k])
          n += int'($signed(bus.spin_delta_i[8*k +: 8]));
        if (step) begin
          n -= s;
          qpos[k] += s;
        end
        if (n > 511) n = 511;
        if (n < -511) n = -511;
        acc[k] = n;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    for (int k = 0; k < NP; k++) begin
      chk($sformatf("dir%0d", k),
          int'(bus.ctrl_dir_o[4*k +: 4]), int'(edir[k]));
      chk($sformatf("p6_%0d", k),
          int'(bus.ctrl_p6_o[k]), int'(ep6[k]));
      chk($sformatf("quad%0d", k),
          int'({bus.quad_a_o[k], bus.quad_b_o[k]}),
          int'(qab(qpos[k])));
    end
  endtask

  task automatic idle();
    bus.joy_i        = '0;
    bus.map_rot_i    = 2'd0;
    bus.af_en_i      = '0;
    bus.sel_key_n_i  = '1;
    bus.sel_joy_n_i  = '1;
    bus.spin_delta_i = '0;
    bus.spin_stb_i   = '0;
    ce = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [1:0]  qprev, qnow;
  logic [1:0]  chg [$];
  int          nchg;
  logic [11:0] pat;

  task automatic track_quad(int n);
    for (int i = 0; i < n; i++) begin
      tick();
      qnow = {bus.quad_a_o[0], bus.quad_b_o[0]};
      if (qnow != qprev) begin
        chg.push_back(qnow);
        nchg++;
      end
      qprev = qnow;
    end
  endtask

  initial begin
    idle();
    do_reset();
    chk("rst_dir", int'(bus.ctrl_dir_o), 8'hFF);
    chk("rst_p6", int'(bus.ctrl_p6_o), 3);
    chk("rst_qa", int'(bus.quad_a_o), 0);

    bus.sel_key_n_i = 2'b10;
    bus.joy_i[31:0] = 32'h1 << 13;
    tick();
    chk("hold_after_rst", int'(bus.ctrl_dir_o[3:0]), 4'hF);
    tick();
    chk("key5", int'(bus.ctrl_dir_o[3:0]), 4'b1001);
    bus.joy_i[31:0] = (32'h1 << 8) | (32'h1 << 13);
    tick(); tick();
    chk("key0_pri", int'(bus.ctrl_dir_o[3:0]), 4'b0011);

    bus.sel_joy_n_i = 2'b10;
    bus.joy_i[31:0] = (32'h1 << 3) | (32'h1 << 9);
    tick(); tick();
    chk("both_dir", int'(bus.ctrl_dir_o[3:0]), 4'b0110);
    bus.joy_i[31:0] = 32'h30;
    tick(); tick();
    chk("both_p6", int'(bus.ctrl_p6_o[0]), 0);

    bus.sel_key_n_i = 2'b11;
    bus.sel_joy_n_i = 2'b00;
    bus.joy_i = '0;
    bus.joy_i[32] = 1'b1;
    bus.map_rot_i = 2'd1;
    tick(); tick();
    chk("rot_pad0", int'(bus.ctrl_dir_o[3:0]), 4'b1110);
    chk("rot_pad1", int'(bus.ctrl_dir_o[7:4]), 4'b1111);

    idle();
    do_reset();
    bus.joy_i[31:0] = 32'h10;
    bus.sel_joy_n_i = 2'b10;
    bus.af_en_i     = 4'b0001;
    tick();
    pat = 12'b0001_1110_0001;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("af_%0d", i),
          int'(bus.ctrl_p6_o[0]), int'(pat[11-i]));
    end

    idle();
    do_reset();
    qprev = 2'b00;
    chg.delete();
    nchg = 0;
    bus.spin_stb_i[0] = 1'b1;
    bus.spin_delta_i[7:0] = 8'd3;
    track_quad(1);
    bus.spin_stb_i = '0;
    track_quad(20);
    chk("fwd_n", chg.size(), 3);
    if (chg.size() == 3) begin
      chk("fwd_1", int'(chg[0]), 2'b10);
      chk("fwd_2", int'(chg[1]), 2'b11);
      chk("fwd_3", int'(chg[2]), 2'b01);
    end
    chg.delete();
    bus.spin_stb_i[0] = 1'b1;
    bus.spin_delta_i[7:0] = 8'hFE;
    track_quad(1);
    bus.spin_stb_i = '0;
    track_quad(20);
    chk("rev_n", chg.size(), 2);
    if (chg.size() == 2) begin
      chk("rev_1", int'(chg[0]), 2'b11);
      chk("rev_2", int'(chg[1]), 2'b10);
    end
    bus.spin_stb_i[0] = 1'b1;
    bus.spin_delta_i[7:0] = 8'd127;
    track_quad(5);
    bus.spin_stb_i = '0;
    chk("sat_dut", int'(dut.acc_q[0]), 511);
    chk("sat_model", acc[0], 511);
    nchg = 0;
    track_quad(1040);
    chk("drain_steps", nchg, 511);

    bus.sel_joy_n_i = 2'b10;
    bus.joy_i[31:0] = 32'h8;
    bus.spin_stb_i[0] = 1'b1;
    bus.spin_delta_i[7:0] = 8'd40;
    tick();
    bus.spin_stb_i = '0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_quad",
        int'({bus.quad_a_o[0], bus.quad_b_o[0]}), 0);
    chk("mid_rst_dir", int'(bus.ctrl_dir_o[3:0]), 4'hF);
    chk("mid_rst_acc", int'(dut.acc_q[0]), 0);
    rst = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      ce  = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < NP; k++)
        bus.joy_i[32*k +: 32] = $urandom & $urandom & $urandom;
      bus.sel_key_n_i  = NP'($urandom);
      bus.sel_joy_n_i  = NP'($urandom);
      bus.af_en_i      = (2*NP)'($urandom);
      bus.map_rot_i    = 2'($urandom);
      bus.spin_delta_i = (8*NP)'($urandom);
      for (int k = 0; k < NP; k++)
        bus.spin_stb_i[k] = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
